// File: rtl/bullet_ctrl.sv
// bullet_ctrl: four-slot bullet manager for a tank game.
//   Each tank i owns bullet slot i. Fire requests are accepted while idle;
//   on every frame_tick one sweep of four cycles moves each active bullet by
//   SPEED pixels through a single shared adder, retiring bullets that would
//   leave the screen. A registered draw lookup reports which bullet (lowest
//   index wins) covers the current VGA pixel and the sprite ROM address.
// Ports:
//   Clk, Reset           clock, asynchronous active-high reset
//   frame_tick           one-cycle pulse at vertical blank start
//   fire_req/dir/x/y     per-tank fire request and spawn state (packed per slot)
//   fire_ack             one-cycle acceptance pulse per slot
//   kill                 per-slot collision kill
//   DrawX, DrawY         current VGA pixel
//   bullet_active/x/y/dir  registered per-slot state (packed per slot)
//   rom_row, rom_col     bullet sprite ROM address for the current pixel
//   pix_valid            current pixel lies in an active bullet's 8x8 box
module bullet_ctrl #(
   parameter int SPEED = 2,
   parameter int SCR_W = 640,
   parameter int SCR_H = 480
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_tick,
   input  logic [3:0]  fire_req,
   input  logic [7:0]  fire_dir,
   input  logic [39:0] fire_x,
   input  logic [35:0] fire_y,
   output logic [3:0]  fire_ack,
   input  logic [3:0]  kill,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   output logic [3:0]  bullet_active,
   output logic [39:0] bullet_x,
   output logic [35:0] bullet_y,
   output logic [7:0]  bullet_dir,
   output logic [4:0]  rom_row,
   output logic [3:0]  rom_col,
   output logic        pix_valid
);

   typedef enum logic {IDLE, UPDATE} state_t;

   localparam logic [9:0] SPD   = 10'(SPEED);
   // Largest coordinate from which a step right/down still fits on screen.
   localparam logic [9:0] LIM_R = 10'(SCR_W - 8 - SPEED);
   localparam logic [9:0] LIM_D = 10'(SCR_H - 8 - SPEED);

   state_t     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic       fire_en, upd_en;

   logic [9:0] x_q   [4];
   logic [9:0] x_d   [4];
   logic [8:0] y_q   [4];
   logic [8:0] y_d   [4];
   logic [1:0] dir_q [4];
   logic [1:0] dir_d [4];
   logic [3:0] act_q, act_d;
   logic [3:0] ack_q, ack_d;

   logic [1:0] cur_dir;
   logic       cur_horiz;
   logic [9:0] coord, sum;
   logic       oob;

   logic       pv_q, pv_d;
   logic [4:0] row_q, row_d;
   logic [3:0] col_q, col_d;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (frame_tick) begin
               state_d = UPDATE;
               idx_d   = '0;
            end
         end
         UPDATE: begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      fire_en = (state_q == IDLE);
      upd_en  = (state_q == UPDATE);
   end

   // ---------------- shared position adder ----------------
   // dir[0] selects the horizontal axis; up and left subtract.
   always_comb begin
      cur_dir   = dir_q[idx_q];
      cur_horiz = cur_dir[0];
      coord     = cur_horiz ? x_q[idx_q] : {1'b0, y_q[idx_q]};
      sum       = (cur_dir == 2'd0 || cur_dir == 2'd3) ? coord - SPD : coord + SPD;
      case (cur_dir)
         2'd0:    oob = (coord < SPD);
         2'd1:    oob = (coord > LIM_R);
         2'd2:    oob = (coord > LIM_D);
         default: oob = (coord < SPD);
      endcase
   end

   // ---------------- slot next state ----------------
   always_comb begin
      act_d = act_q;
      ack_d = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         x_d[i]   = x_q[i];
         y_d[i]   = y_q[i];
         dir_d[i] = dir_q[i];
         if (fire_en && fire_req[i] && !act_q[i] && !kill[i]) begin
            x_d[i]   = fire_x[10*i +: 10];
            y_d[i]   = fire_y[9*i +: 9];
            dir_d[i] = fire_dir[2*i +: 2];
            act_d[i] = 1'b1;
            ack_d[i] = 1'b1;
         end
         if (upd_en && idx_q == 2'(i) && act_q[i] && !kill[i]) begin
            if (oob)            act_d[i] = 1'b0;
            else if (cur_horiz) x_d[i]   = sum;
            else                y_d[i]   = sum[8:0];
         end
         if (kill[i]) act_d[i] = 1'b0;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         act_q <= '0;
         ack_q <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            x_q[i]   <= '0;
            y_q[i]   <= '0;
            dir_q[i] <= '0;
         end
      end else begin
         act_q <= act_d;
         ack_q <= ack_d;
         for (int unsigned i = 0; i < 4; i++) begin
            x_q[i]   <= x_d[i];
            y_q[i]   <= y_d[i];
            dir_q[i] <= dir_d[i];
         end
      end
   end

   // ---------------- draw lookup ----------------
   // Walk from slot 3 down to 0 so the lowest-index hit is written last.
   always_comb begin
      logic [9:0] dx, dy;
      logic [1:0] s;
      pv_d  = 1'b0;
      row_d = '0;
      col_d = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         s  = 2'(3 - k);
         dx = DrawX - x_q[s];
         dy = DrawY - {1'b0, y_q[s]};
         if (act_q[s] && DrawX >= x_q[s] && dx < 10'd8 &&
             DrawY >= {1'b0, y_q[s]} && dy < 10'd8) begin
            pv_d  = 1'b1;
            row_d = {dir_q[s], dy[2:0]};
            col_d = {1'b0, dx[2:0]} + 4'd4;
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pv_q  <= 1'b0;
         row_q <= '0;
         col_q <= '0;
      end else begin
         pv_q  <= pv_d;
         row_q <= row_d;
         col_q <= col_d;
      end
   end

   // ---------------- outputs ----------------
   always_comb begin
      for (int unsigned i = 0; i < 4; i++) begin
         bullet_x[10*i +: 10] = x_q[i];
         bullet_y[9*i +: 9]   = y_q[i];
         bullet_dir[2*i +: 2] = dir_q[i];
      end
   end

   assign bullet_active = act_q;
   assign fire_ack      = ack_q;
   assign pix_valid     = pv_q;
   assign rom_row       = row_q;
   assign rom_col       = col_q;

endmodule

// File: tb/tb_bullet_ctrl.sv
// Self-checking bench for bullet_ctrl: directed scenarios followed by random
// traffic, compared against a frame-level behavioural model of the bullets.
module tb_bullet_ctrl;

   localparam int SPEED = 2;
   localparam int SCR_W = 640;
   localparam int SCR_H = 480;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        frame_tick;
   logic [3:0]  fire_req;
   logic [7:0]  fire_dir;
   logic [39:0] fire_x;
   logic [35:0] fire_y;
   logic [3:0]  fire_ack;
   logic [3:0]  kill;
   logic [9:0]  DrawX, DrawY;
   logic [3:0]  bullet_active;
   logic [39:0] bullet_x;
   logic [35:0] bullet_y;
   logic [7:0]  bullet_dir;
   logic [4:0]  rom_row;
   logic [3:0]  rom_col;
   logic        pix_valid;

   bullet_ctrl #(.SPEED(SPEED), .SCR_W(SCR_W), .SCR_H(SCR_H)) dut (
      .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
      .fire_req(fire_req), .fire_dir(fire_dir), .fire_x(fire_x), .fire_y(fire_y),
      .fire_ack(fire_ack), .kill(kill), .DrawX(DrawX), .DrawY(DrawY),
      .bullet_active(bullet_active), .bullet_x(bullet_x), .bullet_y(bullet_y),
      .bullet_dir(bullet_dir), .rom_row(rom_row), .rom_col(rom_col),
      .pix_valid(pix_valid)
   );

   always #5 Clk = ~Clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: plain integers per bullet plus a sweep position
   // (-1 when no sweep is in progress).
   int m_act [4];
   int m_x   [4];
   int m_y   [4];
   int m_dir [4];
   int m_sweep;
   int m_ack [4];
   int m_pv, m_row, m_col;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dir[i] = 0; m_ack[i] = 0;
      end
      m_sweep = -1;
      m_pv = 0; m_row = 0; m_col = 0;
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      int pv, row, col, nx, ny;
      bit gone;
      pv = 0; row = 0; col = 0;
      for (int i = 3; i >= 0; i--) begin
         if (m_act[i] != 0 && int'(DrawX) >= m_x[i] && int'(DrawX) < m_x[i] + 8 &&
             int'(DrawY) >= m_y[i] && int'(DrawY) < m_y[i] + 8) begin
            pv  = 1;
            row = m_dir[i] * 8 + (int'(DrawY) - m_y[i]);
            col = (int'(DrawX) - m_x[i]) + 4;
         end
      end
      for (int i = 0; i < 4; i++) begin
         m_ack[i] = 0;
         if (kill[i]) begin
            m_act[i] = 0;
         end else if (m_sweep < 0) begin
            if (fire_req[i] && m_act[i] == 0) begin
               m_act[i] = 1;
               m_ack[i] = 1;
               m_x[i]   = int'(fire_x[10*i +: 10]);
               m_y[i]   = int'(fire_y[9*i +: 9]);
               m_dir[i] = int'(fire_dir[2*i +: 2]);
            end
         end else if (m_sweep == i && m_act[i] != 0) begin
            nx = m_x[i]; ny = m_y[i]; gone = 0;
            case (m_dir[i])
               0: if (m_y[i] < SPEED) gone = 1; else ny = m_y[i] - SPEED;
               1: if (m_x[i] + 8 + SPEED > SCR_W) gone = 1; else nx = m_x[i] + SPEED;
               2: if (m_y[i] + 8 + SPEED > SCR_H) gone = 1; else ny = m_y[i] + SPEED;
               default: if (m_x[i] < SPEED) gone = 1; else nx = m_x[i] - SPEED;
            endcase
            if (gone) m_act[i] = 0;
            m_x[i] = nx; m_y[i] = ny;
         end
      end
      if (m_sweep >= 0) m_sweep = (m_sweep == 3) ? -1 : m_sweep + 1;
      else if (frame_tick) m_sweep = 0;
      m_pv = pv; m_row = row; m_col = col;
   endtask

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [39:0] ex;
      logic [35:0] ey;
      logic [7:0]  ed;
      logic [3:0]  ea, eack;
      for (int i = 0; i < 4; i++) begin
         ex[10*i +: 10] = 10'(m_x[i]);
         ey[9*i +: 9]   = 9'(m_y[i]);
         ed[2*i +: 2]   = 2'(m_dir[i]);
         ea[i]          = (m_act[i] != 0);
         eack[i]        = (m_ack[i] != 0);
      end
      chk("active",    40'(bullet_active), 40'(ea));
      chk("bullet_x",  bullet_x,           ex);
      chk("bullet_y",  40'(bullet_y),      40'(ey));
      chk("bullet_dir",40'(bullet_dir),    40'(ed));
      chk("fire_ack",  40'(fire_ack),      40'(eack));
      chk("pix_valid", 40'(pix_valid),     40'(m_pv));
      chk("rom_row",   40'(rom_row),       40'(m_row));
      chk("rom_col",   40'(rom_col),       40'(m_col));
   endtask

   task automatic step();
      model_step();
      @(posedge Clk);
      #1;
      check_all();
   endtask

   task automatic set_fire(input int i, input int dir, input int x, input int y);
      fire_req[i]         = 1'b1;
      fire_dir[2*i +: 2]  = 2'(dir);
      fire_x[10*i +: 10]  = 10'(x);
      fire_y[9*i +: 9]    = 9'(y);
   endtask

   initial begin
      Reset = 1'b1; frame_tick = 1'b0; fire_req = '0; fire_dir = '0;
      fire_x = '0; fire_y = '0; kill = '0; DrawX = '0; DrawY = '0;
      model_reset();
      repeat (2) @(posedge Clk);
      #1;
      check_all();
      Reset = 1'b0;

      // Fire slot 0 right from (100,50), then one sweep moves it to 102.
      set_fire(0, 1, 100, 50);
      step();
      chk("ack0_pulse", 40'(fire_ack), 40'd1);
      fire_req = '0;
      step();
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      repeat (4) step();
      chk("x0_moved", 40'(bullet_x[9:0]), 40'd102);

      // Slot 2 going up from y=1 retires at the end of the sweep, y kept.
      set_fire(2, 0, 10, 1);
      step();
      fire_req = '0;
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      step();
      frame_tick = 1'b1; step(); frame_tick = 1'b0;   // ignored mid-sweep
      repeat (2) step();
      chk("slot2_retired", 40'(bullet_active[2]), 40'd0);
      chk("slot2_y", 40'(bullet_y[26:18]), 40'd1);
      repeat (2) step();

      // All four slots fire together; a repeat request on active slot 1 is held off.
      kill = 4'hF; step(); kill = '0;
      for (int i = 0; i < 4; i++) set_fire(i, i, 300 + 20 * i, 200 + 10 * i);
      step();
      chk("ack_all", 40'(fire_ack), 40'hF);
      fire_req = 4'b0010;
      repeat (2) step();
      chk("ack1_blocked", 40'(fire_ack), 40'd0);
      fire_req = '0;

      // Kill beats fire on an inactive slot; kill during the sweep stops the move.
      kill = 4'hF; step(); kill = '0;
      set_fire(1, 1, 50, 60); kill[1] = 1'b1;
      step();
      chk("kill_vs_fire", 40'(bullet_active[1]), 40'd0);
      kill = '0;
      step();
      fire_req = '0;
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      step();
      kill[1] = 1'b1; step(); kill = '0;
      chk("killed_not_moved", 40'(bullet_x[19:10]), 40'd50);
      repeat (3) step();

      // Draw lookup: slot 0 wins over overlapping slot 3.
      kill = 4'hF; step(); kill = '0;
      set_fire(0, 2, 200, 100); set_fire(3, 1, 200, 100);
      step();
      fire_req = '0;
      DrawX = 10'd203; DrawY = 10'd105;
      step();
      chk("lookup_row", 40'(rom_row), 40'd21);
      chk("lookup_col", 40'(rom_col), 40'd7);
      DrawX = 10'd150; step();

      // Reset asserted while the sweep sits at slot 2.
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      repeat (2) step();
      Reset = 1'b1;
      model_reset();
      #1;
      check_all();
      @(posedge Clk); #1;
      Reset = 1'b0;
      repeat (6) step();

      // Random traffic.
      for (int n = 0; n < 500; n++) begin
         int k;
         frame_tick = ($urandom_range(0, 11) == 0);
         fire_req   = 4'($urandom);
         kill       = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0;
         fire_dir   = 8'($urandom);
         for (int i = 0; i < 4; i++) begin
            fire_x[10*i +: 10] = 10'($urandom_range(0, SCR_W - 1));
            fire_y[9*i +: 9]   = 9'($urandom_range(0, SCR_H - 1));
         end
         k = int'($urandom_range(0, 3));
         DrawX = 10'(m_x[k] + int'($urandom_range(0, 9)));
         DrawY = 10'(m_y[k] + int'($urandom_range(0, 9)));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bullet_ctrl.md
BULLET_CTRL -- requirements
Module: bullet_ctrl

Interface
REQ-001 Parameter SPEED, default 2, pixels moved per frame_tick.
REQ-002 Parameter SCR_W, default 640, screen width in pixels.
REQ-003 Parameter SCR_H, default 480, screen height in pixels.
REQ-004 Clk  in  1  sole clock; all state changes on rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 frame_tick  in  1  one-cycle pulse at vertical blank start.
REQ-007 fire_req  in  4  per-tank fire request; tank i owns bullet slot i; held until acked.
REQ-008 fire_dir  in  8  2 bits per tank: 0 up, 1 right, 2 down, 3 left.
REQ-009 fire_x  in  40  10 bits per tank, spawn top-left X.
REQ-010 fire_y  in  36  9 bits per tank, spawn top-left Y.
REQ-011 fire_ack  out  4  one-cycle acceptance pulse per slot.
REQ-012 kill  in  4  per-slot collision kill, level-sampled.
REQ-013 DrawX  in  10  current VGA pixel X.
REQ-014 DrawY  in  10  current VGA pixel Y.
REQ-015 bullet_active  out  4  slot occupied.
REQ-016 bullet_x  out  40 / bullet_y  out  36 / bullet_dir  out  8  per-slot registered state.
REQ-017 rom_row  out  5  bullet sprite ROM row (32 rows: 4 direction frames of 8).
REQ-018 rom_col  out  4  bullet sprite ROM column (16 columns).
REQ-019 pix_valid  out  1  DrawX/DrawY falls inside an active bullet's 8x8 box.

Function
REQ-020 FSM states: IDLE, UPDATE; one shared position adder, one slot updated per cycle.
REQ-021 IDLE + frame_tick -> UPDATE with idx=0; UPDATE processes slot idx, idx++, after idx=3 -> IDLE (exactly 4 UPDATE cycles).
REQ-022 frame_tick during UPDATE is ignored.
REQ-023 UPDATE, active slot: move SPEED along dir (up y-=, right x+=, down y+=, left x-=); inactive slot unchanged.
REQ-024 Bounds: slot deactivates instead of moving if up y<SPEED, left x<SPEED, right x+8+SPEED>SCR_W, down y+8+SPEED>SCR_H.
REQ-025 Fire accepted only in IDLE, when fire_req[i]=1, slot i inactive and kill[i]=0; next edge loads x/y/dir, sets active, pulses fire_ack[i] for one cycle.
REQ-026 Multiple simultaneous fire requests in IDLE all accepted in the same cycle (independent slots).
REQ-027 fire_req during UPDATE or to an active slot stays pending, no ack; the requester keeps it asserted.
REQ-028 kill[i]=1 clears active[i] on next edge in any state; kill overrides fire and move for that slot in that cycle.
REQ-029 Draw lookup: lowest-index active slot with x<=DrawX<x+8 and y<=DrawY<y+8 wins.
REQ-030 Lookup registered, 1-cycle latency: pix_valid, rom_row={dir,(DrawY-y)[2:0]}, rom_col=(DrawX-x)[2:0]+4.
REQ-031 No hit: pix_valid=0, rom_row=0, rom_col=0.
REQ-032 Lookup uses slot state registered before the edge; update and lookup run concurrently.

Reset
REQ-033 Reset asserted: state=IDLE, idx=0, bullet_active=0, bullet_x/y/dir=0, fire_ack=0, pix_valid=0, rom_row=0, rom_col=0, immediately and asynchronously.
REQ-034 Reset mid-UPDATE aborts the sweep; after release, FSM waits in IDLE for the next frame_tick.

Verification
REQ-035 IDLE, fire_req[0]=1, dir=1, x=100, y=50 -> fire_ack[0] pulses 1 cycle, active[0]=1, x=100; after frame_tick and 4 cycles, x=102.
REQ-036 Slot 2, dir=0, y=1, frame_tick -> active[2]=0 at end of sweep, y still 1.
REQ-037 fire_req on slots 0-3 together in IDLE -> fire_ack=4'b1111 in one cycle; repeat fire_req[1] while active -> no ack.
REQ-038 kill[1] and fire_req[1] in the same IDLE cycle on an inactive slot -> no ack, active[1]=0; kill of an active slot during UPDATE -> cleared, not moved.
REQ-039 Slot 0 at (200,100) dir 2, DrawX=203, DrawY=105 -> next cycle pix_valid=1, rom_row=21, rom_col=7; overlapping slot 3 ignored.
REQ-040 Reset asserted at UPDATE idx=2 -> all outputs 0 immediately; after release, no movement until the next frame_tick.
